// File: rtl/gray_ptr_sync.sv
// Brings a foreign-domain Gray pointer into CLK, converts it to binary and derives FIFO level/full/empty.
// Define GRAY_PTR_SYNC_CHECK_EN to build the sticky Gray-jump / level-overflow checker on `error`.
module gray_ptr_sync #(
  parameter int unsigned width  = 10,
  parameter int unsigned stages = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [width-1:0] remoteGray,
  input  logic [width-1:0] localBin,
  output logic [width-1:0] syncBin,
  output logic             syncBin__RDY,
  output logic [width-1:0] level,
  output logic             full,
  output logic             empty,
  output logic [1:0]       error,
  input  logic             clearError__ENA,
  output logic             clearError__RDY
);

  localparam int unsigned FILL_W = $clog2(stages + 2);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(stages + 1);
  localparam logic [FILL_W-1:0] FILL_RDY = FILL_W'(stages);
  localparam logic [width-1:0] HALF = {1'b1, {(width-1){1'b0}}};

  logic [width-1:0]  g_q [stages];
  logic [width-1:0]  g_last;
  logic [width-1:0]  bin_c;
  logic [width-1:0]  level_c;
  logic [FILL_W-1:0] fill_q;

  assign g_last          = g_q[stages-1];
  assign level_c         = localBin - syncBin;
  assign clearError__RDY = 1'b1;

  // Gray to binary: bit i is the XOR of all Gray bits at or above i
  always_comb begin
    bin_c = '0;
    for (int i = 0; i < int'(width); i++) begin
      bin_c[i] = ^(g_last >> i);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < int'(stages); i++) begin
        g_q[i] <= '0;
      end
      syncBin      <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      fill_q       <= '0;
      syncBin__RDY <= 1'b0;
    end else begin
      g_q[0] <= remoteGray;
      for (int i = 1; i < int'(stages); i++) begin
        g_q[i] <= g_q[i-1];
      end
      syncBin <= bin_c;
      if (fill_q != FILL_MAX) begin
        fill_q <= fill_q + FILL_W'(1);
      end
      syncBin__RDY <= (fill_q >= FILL_RDY);
      // Level only tracks once syncBin holds a post-reset sample
      if (syncBin__RDY) begin
        level <= level_c;
        full  <= (level_c == HALF);
        empty <= (level_c == '0);
      end
    end
  end

`ifdef GRAY_PTR_SYNC_CHECK_EN
  logic [width-1:0] prev_q;
  logic [width-1:0] diff_c;
  logic [1:0]       set_c;

  // More than one bit changed between consecutive synchronized samples means a bad crossing
  always_comb begin
    diff_c = g_last ^ prev_q;
    set_c  = 2'b00;
    if (syncBin__RDY) begin
      set_c[0] = ((diff_c & (diff_c - width'(1))) != '0);
      set_c[1] = (level_c > HALF);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      prev_q <= '0;
      error  <= 2'b00;
    end else begin
      prev_q <= g_last;
      error  <= (clearError__ENA ? 2'b00 : error) | set_c;
    end
  end
`else
  logic clear_unused;

  assign clear_unused = clearError__ENA;
  assign error        = 2'b00;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync at width=4, stages=2.
module tb_gray_ptr_sync;

  logic       CLK;
  logic       nRST;
  logic [3:0] remoteGray;
  logic [3:0] localBin;
  logic [3:0] syncBin;
  logic       syncBin__RDY;
  logic [3:0] level;
  logic       full;
  logic       empty;
  logic [1:0] error;
  logic       clearError__ENA;
  logic       clearError__RDY;

  int n_total = 0;
  int n_bad   = 0;

`ifdef GRAY_PTR_SYNC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  gray_ptr_sync #(.width(4), .stages(2)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .remoteGray      (remoteGray),
    .localBin        (localBin),
    .syncBin         (syncBin),
    .syncBin__RDY    (syncBin__RDY),
    .level           (level),
    .full            (full),
    .empty           (empty),
    .error           (error),
    .clearError__ENA (clearError__ENA),
    .clearError__RDY (clearError__RDY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] gray(input logic [3:0] k);
    return k ^ (k >> 1);
  endfunction

  initial begin
    nRST            = 1'b0;
    remoteGray      = 4'b0110;
    localBin        = 4'd0;
    clearError__ENA = 1'b0;

    // Reset held with a live pointer on the input
    step(3);
    check("rst_sync", syncBin, 0);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_err", error, 0);
    check("rst_rdy", syncBin__RDY, 0);
    check("clr_rdy", clearError__RDY, 1);

    nRST       = 1'b1;
    remoteGray = 4'b0000;
    localBin   = 4'd5;
    step(1);
    check("rdy_e1", syncBin__RDY, 0);
    step(1);
    check("rdy_e2", syncBin__RDY, 0);
    check("lvl_hold", level, 0);
    step(1);
    check("rdy_e3", syncBin__RDY, 1);
    step(1);
    check("lvl_first", level, 5);

    // Latency: Gray 0 -> 1 sampled at edge t
    remoteGray = 4'b0001;
    step(2);
    check("lat_sync_t1", syncBin, 0);
    step(1);
    check("lat_sync_t2", syncBin, 1);
    check("lat_lvl_t2", level, 5);
    step(1);
    check("lat_lvl_t3", level, 4);

    // Full, then walk the Gray sequence up to 8 for empty
    localBin   = 4'd8;
    remoteGray = 4'b0000;
    step(4);
    check("full_lvl", level, 8);
    check("full_full", full, 1);
    check("full_empty", empty, 0);
    for (int k = 1; k <= 8; k++) begin
      remoteGray = gray(4'(k));
      step(1);
    end
    step(4);
    check("empty_sync", syncBin, 8);
    check("empty_lvl", level, 0);
    check("empty_empty", empty, 1);
    check("empty_full", full, 0);
    check("empty_err", error, 0);

    // Wrap: local 1, remote binary 15
    remoteGray = 4'b1000;
    step(3);
    check("wrap_sync", syncBin, 15);
    localBin = 4'd1;
    step(1);
    check("wrap_lvl", level, 2);
    step(2);
    check("wrap_err", error, 0);
    check("wrap_empty", empty, 0);

    // Return to pointer 0 cleanly
    remoteGray = 4'b0000;
    step(3);
    localBin = 4'd0;
    step(1);
    check("zero_lvl", level, 0);

    // Gray jump 0000 -> 0011
    remoteGray = 4'b0011;
    step(3);
    check("jump_sync", syncBin, 2);
    check("jump_err", error, CHK ? 2'b01 : 2'b00);
    localBin = 4'd2;
    step(3);
    check("jump_sticky", error, CHK ? 2'b01 : 2'b00);
    check("jump_lvl", level, 0);
    clearError__ENA = 1'b1;
    step(1);
    clearError__ENA = 1'b0;
    check("jump_clear", error, 0);

    // Clear coincident with a new jump 0011 -> 0000
    remoteGray = 4'b0000;
    step(2);
    clearError__ENA = 1'b1;
    step(1);
    clearError__ENA = 1'b0;
    check("set_wins", error, CHK ? 2'b01 : 2'b00);
    clearError__ENA = 1'b1;
    step(1);
    clearError__ENA = 1'b0;
    check("reclear", error, 0);
    check("post_lvl", level, 2);

    // Overflow: level 9 exceeds the depth of 8
    localBin = 4'd9;
    step(1);
    check("ovf_lvl", level, 9);
    check("ovf_err", error, CHK ? 2'b10 : 2'b00);
    check("ovf_full", full, 0);
    localBin = 4'd8;
    step(1);
    check("ovf_back_full", full, 1);
    check("ovf_sticky", error, CHK ? 2'b10 : 2'b00);

    // Reset mid-operation
    nRST = 1'b0;
    step(1);
    check("mid_sync", syncBin, 0);
    check("mid_lvl", level, 0);
    check("mid_empty", empty, 1);
    check("mid_full", full, 0);
    check("mid_err", error, 0);
    check("mid_rdy", syncBin__RDY, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
